occ_axil_responder: RTL and testbench
=====================================

Name: occ_axil_responder

Overview:
- AXI4-Lite read-only responder that serves 256-bit occurrence-table words to one Read2Seed read initiator.
- Fronts a synchronous on-chip RAM with fixed read latency. Synthesizable replacement for the simulation memory model, one instance per process-block channel.
- Supports multiple outstanding reads using credits, an in-order response queue and SLVERR for bad addresses.

Parameters:
- AW, 40: AXI address width.
- DW, 256: data width; byte stride = DW/8 = 32.
- BASE_ADDR, 40'h0: byte address mapped to RAM word 0.
- DEPTH_AW, 10: RAM word-address width; RAM holds 2**DEPTH_AW words.
- RAM_LAT, 2: RAM read latency in cycles, >=1.
- QU_AW, 3: response queue depth is 2**QU_AW; this is also the maximum number of outstanding reads.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- s_axi_araddr, in, AW: read address.
- s_axi_arprot, in, 3: ignored.
- s_axi_arvalid, in, 1: address valid.
- s_axi_arready, out, 1: address ready.
- s_axi_rdata, out, DW: read data.
- s_axi_rresp, out, 2: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_rvalid, out, 1: response valid.
- s_axi_rready, in, 1: response ready.
- mem_en, out, 1: RAM read enable.
- mem_addr, out, DEPTH_AW: RAM word address.
- mem_rdata, in, DW: RAM data, valid RAM_LAT cycles after mem_en.

Behaviour:
- Reset (async assert, sync release):
  - outputs: arready=0, rvalid=0, rresp=0, rdata=0, mem_en=0;
  - state: credit counter=0, tag pipeline cleared, queue emptied.
  - Asserting reset mid-operation drops all in-flight reads; no stale beat appears after release.
- Credits:
  - cnt = reads accepted minus R handshakes, range 0..2**QU_AW.
  - arready = !rst && cnt < 2**QU_AW. It is registered-derived and does not depend on arvalid.
  - AR handshake alone: +1. R handshake alone: -1. Both in the same cycle: unchanged.
- Address check:
  - off = araddr - BASE_ADDR.
  - Error if any of: araddr < BASE_ADDR; off[4:0] != 0; off>>5 >= 2**DEPTH_AW.
- Issue, in the AR handshake cycle t:
  - mem_en = arvalid & arready & !err, combinational.
  - mem_addr = off[5 +: DEPTH_AW].
  - A tag {valid=1, err} enters a RAM_LAT-deep shift pipeline. Error reads consume a slot but do not pulse mem_en.
- Capture at pipeline output (cycle t+RAM_LAT), write to queue:
  - OKAY beat: {2'b00, mem_rdata}.
  - Error beat: {2'b10, '0}.
- Response:
  - Queue is show-ahead; rvalid is asserted at cycle t+RAM_LAT+1 when the queue was empty.
  - rdata/rresp stay stable while rvalid && !rready.
  - Pop on rvalid && rready.
- Throughput: one read per cycle sustained with rready=1.
- Ordering: responses are strictly in AR order.
- Overflow: the credit scheme guarantees the queue never overflows. The queue asserts an internal overflow flag, and simulation assertions check it stays 0.
- Empty: rvalid=0 and rdata holds its last value.

Optional Feature:
- Macro: OCC_RESP_STATS_EN.
- With the macro defined, add the following outputs, each reset to 0 and saturating at all-ones:
  - stat_rd_cnt[31:0]: counts AR handshakes.
  - stat_err_cnt[31:0]: counts SLVERR beats returned.
  - stat_max_outst[QU_AW:0]: high-water mark of the credit counter.
- Without the macro: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package BwaMemDefines gains:
  - localparams AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10;
  - localparam OCC_WORD_BYTES=32;
  - packed typedef OccRespBeat {logic [1:0] resp; logic [255:0] data}.
- One sub-module, occ_resp_fifo: synchronous show-ahead FIFO, DW+2 wide, 2**QU_AW deep, with data_cnt and overflow flag.
- Credit counter, tag pipeline and address check stay in the top.

Test Plan (RAM_LAT=2, BASE_ADDR=0, DEPTH_AW=10, QU_AW=3, RAM word n = n replicated):
- Single read at araddr 0x40 -> mem_en for 1 cycle with mem_addr=2 -> rvalid 3 cycles after handshake, rdata=word 2, rresp=00.
- Misaligned araddr 0x41, then out-of-range 0x8000 -> no mem_en; each returns rresp=10, rdata=0, same latency, in order.
- 8 back-to-back reads to 0x0..0xE0 with rready=0 -> all 8 accepted; arready low from the cycle after the 8th handshake; rready=1 -> words 0..7 in order; arready high the cycle after the first R handshake.
- Simultaneous AR and R handshake with cnt=8 -> the AR is not accepted until cnt<8; with cnt=5, cnt stays 5.
- 10000 random reads (mixed valid/invalid addresses), 25% arvalid/rready duty -> scoreboard exact in order, no loss, cnt never >8, overflow flag never set.
- Reset asserted with 4 reads outstanding -> rvalid/arready drop asynchronously; after release arready=1 and no beat appears until a new AR; with OCC_RESP_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/occ_axil_responder_pkg.sv
// rtl/occ_axil_responder_pkg.sv - shared AXI response codes and occurrence-word beat type
package BwaMemDefines;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         OCC_WORD_BYTES  = 32;

  typedef struct packed {
    logic [1:0]   resp;
    logic [255:0] data;
  } OccRespBeat;

endpackage

// File: rtl/occ_axil_responder_fifo.sv
// rtl/occ_axil_responder_fifo.sv - show-ahead response FIFO with occupancy and sticky overflow flag
module occ_resp_fifo #(
  parameter int W  = 258,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   data_cnt,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          full, empty, wr_en, rd_en;

  always_comb begin
    full       = cnt_q[AW];
    empty      = (cnt_q == '0);
    wr_en      = push && !full;
    rd_en      = pop && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d      = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    // A push into a full FIFO is lost even if a pop happens the same cycle.
    overflow_d = overflow_q || (push && full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata    = mem_q[rd_ptr_q];
  assign data_cnt = cnt_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/occ_axil_responder.sv
// rtl/occ_axil_responder.sv - credit-based AXI4-Lite read responder over a fixed-latency RAM
// Optional statistics outputs are enabled by defining OCC_RESP_STATS_EN.
module occ_axil_responder
  import BwaMemDefines::*;
#(
  parameter int            AW        = 40,
  parameter int            DW        = 256,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            DEPTH_AW  = 10,
  parameter int            RAM_LAT   = 2,
  parameter int            QU_AW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       s_axi_araddr,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DW-1:0]       s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                mem_en,
  output logic [DEPTH_AW-1:0] mem_addr,
  input  logic [DW-1:0]       mem_rdata
`ifdef OCC_RESP_STATS_EN
  ,
  output logic [31:0]         stat_rd_cnt,
  output logic [31:0]         stat_err_cnt,
  output logic [QU_AW:0]      stat_max_outst
`endif
);

  localparam int OFF_LSB = $clog2(OCC_WORD_BYTES);

  logic [QU_AW:0]   cnt_q, cnt_d;
  logic [RAM_LAT-1:0] tag_vld_q, tag_vld_d, tag_err_q, tag_err_d;
  logic [DW-1:0]    last_data_q, last_data_d;
  logic [1:0]       last_resp_q, last_resp_d;
  logic [AW-1:0]    off;
  logic             addr_err, arready, ar_hs, rvalid, r_hs;
  logic             fifo_push, fifo_overflow;
  logic [DW+1:0]    fifo_wdata, fifo_rdata;
  logic [QU_AW:0]   fifo_cnt;
  logic             unused_ok;

  assign unused_ok = ^s_axi_arprot;

  always_comb begin
    off       = s_axi_araddr - BASE_ADDR;
    addr_err  = (s_axi_araddr < BASE_ADDR) || (|off[OFF_LSB-1:0]) ||
                (|off[AW-1:OFF_LSB+DEPTH_AW]);
    // Credits count beats owed, so arready never looks at arvalid.
    arready   = !rst && !cnt_q[QU_AW];
    ar_hs     = s_axi_arvalid && arready;
    rvalid    = (fifo_cnt != '0);
    r_hs      = rvalid && s_axi_rready;
    cnt_d     = cnt_q + {{QU_AW{1'b0}}, ar_hs} - {{QU_AW{1'b0}}, r_hs};
    tag_vld_d = '0;
    tag_err_d = '0;
    tag_vld_d[0] = ar_hs;
    tag_err_d[0] = addr_err;
    for (int i = 1; i < RAM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_err_d[i] = tag_err_q[i-1];
    end
    fifo_push  = tag_vld_q[RAM_LAT-1];
    fifo_wdata = tag_err_q[RAM_LAT-1] ? {AXI_RESP_SLVERR, {DW{1'b0}}}
                                      : {AXI_RESP_OKAY, mem_rdata};
    last_data_d = r_hs ? fifo_rdata[DW-1:0] : last_data_q;
    last_resp_d = r_hs ? fifo_rdata[DW+:2]  : last_resp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      tag_vld_q   <= '0;
      tag_err_q   <= '0;
      last_data_q <= '0;
      last_resp_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_err_q   <= tag_err_d;
      last_data_q <= last_data_d;
      last_resp_q <= last_resp_d;
    end
  end

  occ_resp_fifo #(
    .W  (DW + 2),
    .AW (QU_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .wdata    (fifo_wdata),
    .pop      (r_hs),
    .rdata    (fifo_rdata),
    .data_cnt (fifo_cnt),
    .overflow (fifo_overflow)
  );

  overflow_never_set: assert property (@(posedge clk) disable iff (rst) !fifo_overflow);

  assign s_axi_arready = arready;
  assign s_axi_rvalid  = rvalid;
  // Empty queue exposes the last popped beat rather than a stale slot.
  assign s_axi_rdata   = rvalid ? fifo_rdata[DW-1:0] : last_data_q;
  assign s_axi_rresp   = rvalid ? fifo_rdata[DW+:2]  : last_resp_q;
  assign mem_en        = ar_hs && !addr_err;
  assign mem_addr      = off[OFF_LSB +: DEPTH_AW];

`ifdef OCC_RESP_STATS_EN
  logic [31:0]    stat_rd_q, stat_rd_d, stat_err_q, stat_err_d;
  logic [QU_AW:0] stat_max_q, stat_max_d;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_err_d = stat_err_q;
    stat_max_d = stat_max_q;
    if (ar_hs && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + 32'd1;
    if (r_hs && (fifo_rdata[DW+:2] == AXI_RESP_SLVERR) && (stat_err_q != '1))
      stat_err_d = stat_err_q + 32'd1;
    if (cnt_d > stat_max_q) stat_max_d = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q  <= '0;
      stat_err_q <= '0;
      stat_max_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_err_q <= stat_err_d;
      stat_max_q <= stat_max_d;
    end
  end

  assign stat_rd_cnt    = stat_rd_q;
  assign stat_err_cnt   = stat_err_q;
  assign stat_max_outst = stat_max_q;
`endif

endmodule

// File: tb/tb_occ_axil_responder.sv
// tb/tb_occ_axil_responder.sv - directed and scoreboarded bench for occ_axil_responder
module tb_occ_axil_responder;
  import BwaMemDefines::*;

  localparam int NRAND = 10000;

  logic         clk = 1'b0;
  logic         rst;
  logic [39:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid, arready;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic         mem_en;
  logic [9:0]   mem_addr;
  logic [255:0] mem_rdata, p1, p2;
`ifdef OCC_RESP_STATS_EN
  logic [31:0]  stat_rd_cnt, stat_err_cnt;
  logic [3:0]   stat_max_outst;
`endif

  int checks = 0;
  int failures = 0;
  int n_iss, n_rcv, cyc, outst;
  logic ar_fire, done;
  OccRespBeat sb[$];

  always #5 clk = ~clk;

  occ_axil_responder #(
    .AW(40), .DW(256), .BASE_ADDR(40'h0), .DEPTH_AW(10), .RAM_LAT(2), .QU_AW(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata)
`ifdef OCC_RESP_STATS_EN
    ,
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_err_cnt   (stat_err_cnt),
    .stat_max_outst (stat_max_outst)
`endif
  );

  function automatic logic [255:0] word(int n);
    return {8{n[31:0]}};
  endfunction

  // RAM with two-cycle latency; unread cycles return a poison pattern.
  always @(posedge clk) begin
    p1 <= mem_en ? word(int'(mem_addr)) : {8{32'hDEADBEEF}};
    p2 <= p1;
  end
  assign mem_rdata = p2;

  task automatic check(string tag, logic [259:0] got, logic [259:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic OccRespBeat exp_beat(logic [39:0] a);
    OccRespBeat b;
    if (a[4:0] != 5'd0 || a[39:15] != 25'd0) begin
      b.resp = 2'b10;
      b.data = '0;
    end else begin
      b.resp = 2'b00;
      b.data = word(int'(a[14:5]));
    end
    return b;
  endfunction

  function automatic logic [39:0] rand_addr();
    int k = $urandom_range(0, 3);
    logic [39:0] a;
    if (k < 2)       a = 40'($urandom_range(0, 1023)) << 5;
    else if (k == 2) a = (40'($urandom_range(0, 1023)) << 5) | 40'($urandom_range(1, 31));
    else             a = ({8'($urandom), 32'($urandom)} | 40'h8000) & ~40'h1F;
    return a;
  endfunction

  initial begin
    #1200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arvalid = 1'b1; araddr = '0; arprot = '0; rready = 1'b0;
    step; step; smp;
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_en", mem_en, 0);
    step; rst = 1'b0; arvalid = 1'b0; smp;
    check("rel_arready", arready, 1);

    // single OKAY read
    step; rready = 1'b1; araddr = 40'h40; arvalid = 1'b1; smp;
    check("t1_arready", arready, 1);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 2);
    step; arvalid = 1'b0; smp;
    check("t1_mem_en_off", mem_en, 0);
    check("t1_rvalid_t1", rvalid, 0);
    step; smp; check("t1_rvalid_t2", rvalid, 0);
    step; smp;
    check("t1_rvalid", rvalid, 1);
    check("t1_beat", {rresp, rdata}, {2'b00, word(2)});
    step; smp;
    check("t1_rvalid_off", rvalid, 0);
    check("t1_hold", rdata, word(2));

    // misaligned then out-of-range
    step; araddr = 40'h41; arvalid = 1'b1; smp;
    check("t2_arready", arready, 1);
    check("t2_mis_mem_en", mem_en, 0);
    step; araddr = 40'h8000; smp;
    check("t2_oor_mem_en", mem_en, 0);
    step; arvalid = 1'b0; smp; check("t2_rvalid_early", rvalid, 0);
    step; smp; check("t2_beat0", {rvalid, rresp, rdata}, {1'b1, 2'b10, 256'd0});
    step; smp; check("t2_beat1", {rvalid, rresp, rdata}, {1'b1, 2'b10, 256'd0});
    step; smp; check("t2_rvalid_off", rvalid, 0);

    // fill all credits with rready low
    for (int i = 0; i < 8; i++) begin
      step; rready = 1'b0; arvalid = 1'b1; araddr = 40'(i * 32); smp;
      check("t3_arready", arready, 1);
      check("t3_mem_addr", mem_addr, i);
    end
    step; arvalid = 1'b0; smp; check("t3_ar_full", arready, 0);
    step; step; smp; check("t3_head", {rvalid, rresp, rdata}, {1'b1, 2'b00, word(0)});
    step; rready = 1'b1; smp;
    check("t3_ar_still_full", arready, 0);
    check("t3_beat0", {rvalid, rdata}, {1'b1, word(0)});
    for (int i = 1; i < 8; i++) begin
      step; smp;
      if (i == 1) check("t3_ar_reopen", arready, 1);
      check("t3_beat", {rvalid, rresp, rdata}, {1'b1, 2'b00, word(i)});
    end
    step; smp; check("t3_drained", rvalid, 0);

    // AR and R together while credits are exhausted
    for (int i = 0; i < 8; i++) begin
      step; rready = 1'b0; arvalid = 1'b1; araddr = 40'((8 + i) * 32); smp;
      check("t4_arready", arready, 1);
    end
    step; araddr = 40'(16 * 32); rready = 1'b1; smp;
    check("t4_ar_blocked", arready, 0);
    check("t4_beat8", {rvalid, rdata}, {1'b1, word(8)});
    step; smp;
    check("t4_ar_accept", arready, 1);
    check("t4_beat9", {rvalid, rdata}, {1'b1, word(9)});
    step; arvalid = 1'b0;
    for (int i = 10; i <= 16; i++) begin
      smp; check("t4_beat", {rvalid, rresp, rdata}, {1'b1, 2'b00, word(i)});
      step;
    end
    smp; check("t4_drained", rvalid, 0);

    // AR and R together with five outstanding keeps the count at five
    for (int i = 0; i < 5; i++) begin
      step; rready = 1'b0; arvalid = 1'b1; araddr = 40'((20 + i) * 32); smp;
      check("t5_arready", arready, 1);
    end
    step; araddr = 40'(25 * 32); rready = 1'b1; smp;
    check("t5_both_ar", arready, 1);
    check("t5_both_r", {rvalid, rdata}, {1'b1, word(20)});
    for (int i = 26; i <= 28; i++) begin
      step; rready = 1'b0; araddr = 40'(i * 32); smp;
      check("t5_ar_room", arready, 1);
    end
    step; araddr = 40'(29 * 32); smp; check("t5_ar_full", arready, 0);
    step; arvalid = 1'b0; rready = 1'b1;
    for (int i = 21; i <= 28; i++) begin
      smp; check("t5_beat", {rvalid, rresp, rdata}, {1'b1, 2'b00, word(i)});
      step;
    end
    smp; check("t5_drained", rvalid, 0);

    // random traffic against an in-order scoreboard and a credit model
    n_iss = 0; n_rcv = 0; cyc = 0; outst = 0; ar_fire = 1'b0; done = 1'b0;
    fork
      begin
        while (!done) begin
          step;
          if (arvalid && ar_fire) arvalid = 1'b0;
          if (!arvalid && n_iss < NRAND && $urandom_range(0, 3) == 0) begin
            arvalid = 1'b1;
            araddr  = rand_addr();
            n_iss++;
          end
          rready = ($urandom_range(0, 3) == 0);
        end
      end
      begin
        while (!done) begin
          smp;
          cyc++;
          check("rnd_arready", arready, outst < 8);
          ar_fire = arvalid && arready;
          if (rvalid && rready) begin
            if (sb.size() == 0) check("rnd_spurious", 1, 0);
            else check("rnd_beat", {rresp, rdata}, sb.pop_front());
            outst--;
            n_rcv++;
          end
          if (ar_fire) begin
            sb.push_back(exp_beat(araddr));
            outst++;
          end
          if (n_rcv == NRAND || cyc > 90000) done = 1'b1;
        end
      end
    join
    step; arvalid = 1'b0; rready = 1'b0; smp;
    check("rnd_complete", n_rcv, NRAND);
    check("rnd_no_overflow", dut.u_fifo.overflow_q, 0);

    // reset with four reads outstanding
    for (int i = 1; i <= 4; i++) begin
      step; arvalid = 1'b1; araddr = 40'(i * 32); smp;
    end
    step; arvalid = 1'b0; step; step; smp;
    check("t6_rvalid_pre", rvalid, 1);
    #2; rst = 1'b1; #1;
    check("t6_rvalid_async", rvalid, 0);
    check("t6_arready_async", arready, 0);
    step; step; rst = 1'b0; rready = 1'b1; smp;
    check("t6_arready_rel", arready, 1);
    check("t6_rvalid_rel", rvalid, 0);
`ifdef OCC_RESP_STATS_EN
    check("t6_stat_rd", stat_rd_cnt, 0);
    check("t6_stat_err", stat_err_cnt, 0);
    check("t6_stat_max", stat_max_outst, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      step; smp; check("t6_no_stale", rvalid, 0);
    end
    step; araddr = 40'h60; arvalid = 1'b1; smp;
    check("t6_mem_addr", mem_addr, 3);
    step; arvalid = 1'b0; step; step; smp;
    check("t6_recover", {rvalid, rresp, rdata}, {1'b1, 2'b00, word(3)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
